// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the cache geometry, the refill FSM state type and the helpers
// that split a fetch address into tag / index / word offset.
package icache_pkg;

    // Cache geometry; both must be powers of two.
    localparam int LINES          = 64;
    localparam int WORDS_PER_LINE = 4;

    localparam int INDEX_W = $clog2(LINES);
    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int TAG_W   = 32 - INDEX_W - OFF_W - 2;

    typedef enum logic {
        IDLE,
        REFILL
    } stateT;

    function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] pc);
        return pc[31:32-TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] pc);
        return pc[INDEX_W+OFF_W+1:OFF_W+2];
    endfunction

    function automatic logic [OFF_W-1:0] get_offset(input logic [31:0] pc);
        return pc[OFF_W+1:2];
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction word storage for the cache.
// Ports:
//   clk          - clock, write on rising edge
//   we/waddr/wdata - synchronous write port
//   raddr/rdata  - asynchronous read port (same-cycle hit data)
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache.
// Hits return the instruction combinationally; a miss stalls fetch while
// the whole line is refilled one word at a time from instruction memory.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cpu_pc, cpu_req     - fetch address and fetch valid
//   flush               - invalidate every line
//   cpu_instr, cpu_stall - fetched word (valid when req && !stall), hold fetch
//   mem_req, mem_addr   - registered single-word read request
//   mem_rdata, mem_rvalid - returned word, one-cycle pulse per request
import icache_pkg::*;

module inst_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_pc,
    input  logic        cpu_req,
    input  logic        flush,
    output logic [31:0] cpu_instr,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    logic [LINES-1:0]   validArr;
    logic [TAG_W-1:0]   tagArr [LINES];

    stateT              state, nextState;
    logic [TAG_W-1:0]   lineTag;
    logic [INDEX_W-1:0] lineIdx;
    logic [OFF_W-1:0]   cnt;
    logic [OFF_W-1:0]   nextCnt;
    logic               kill;

    logic [TAG_W-1:0]   pcTag;
    logic [INDEX_W-1:0] pcIdx;
    logic [OFF_W-1:0]   pcOff;
    logic               hit;
    logic               startMiss;
    logic               wordDone;
    logic               lastWord;
    logic [31:0]        rdata;

    assign pcTag = get_tag(cpu_pc);
    assign pcIdx = get_index(cpu_pc);
    assign pcOff = get_offset(cpu_pc);

    // Lookups are only trusted in IDLE: during a refill the line being
    // written may alias the fetch address with a half-filled data array.
    assign hit       = validArr[pcIdx] && (tagArr[pcIdx] == pcTag) && (state == IDLE);
    assign cpu_stall = cpu_req && !hit;
    assign cpu_instr = hit ? rdata : '0;

    assign startMiss = (state == IDLE) && cpu_req && !hit;
    assign wordDone  = (state == REFILL) && mem_rvalid;
    assign lastWord  = (cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign nextCnt   = cnt + 1'b1;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startMiss) nextState = REFILL;
            REFILL:  if (wordDone && lastWord) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            cnt      <= '0;
            kill     <= 1'b0;
            validArr <= '0;
        end else begin
            state <= nextState;
            if (startMiss) begin
                cnt      <= '0;
                kill     <= 1'b0;
                mem_req  <= 1'b1;
                mem_addr <= {pcTag, pcIdx, {OFF_W{1'b0}}, 2'b00};
            end else if (wordDone) begin
                if (!lastWord) begin
                    cnt      <= nextCnt;
                    mem_addr <= {lineTag, lineIdx, nextCnt, 2'b00};
                end else begin
                    mem_req <= 1'b0;
                end
            end
            // A flush seen mid-refill must also stop the in-flight line
            // from becoming valid when it completes.
            if (flush && state == REFILL) kill <= 1'b1;
            if (flush)
                validArr <= '0;
            else if (wordDone && lastWord)
                validArr[lineIdx] <= !kill;
        end
    end

    // Line address latch and tag array carry no reset: validity alone
    // decides whether their contents are used.
    always_ff @(posedge clk) begin
        if (startMiss) begin
            lineTag <= pcTag;
            lineIdx <= pcIdx;
        end
        if (wordDone && lastWord) tagArr[lineIdx] <= lineTag;
    end

    icache_data_ram #(
        .DEPTH(LINES * WORDS_PER_LINE)
    ) uDataRam (
        .clk  (clk),
        .we   (wordDone),
        .waddr({lineIdx, cnt}),
        .wdata(mem_rdata),
        .raddr({pcIdx, pcOff}),
        .rdata(rdata)
    );

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
Direct-mapped, read-only instruction cache between the CPU fetch port (pcF/instrF of the pipeline top) and an external instruction memory with a word-wise valid handshake.
- Hits return the instruction combinationally in the same cycle.
- Misses raise cpu_stall, which is ORed into the fetch-stage stall (stallF/stallD), while a full line is refilled word by word.

Parameters:
LINES, 64, number of cache lines; power of 2; INDEX_W = log2(LINES).
WORDS_PER_LINE, 4, 32-bit words per line; power of 2; OFF_W = log2(WORDS_PER_LINE).
TAG_W, derived, 32 - INDEX_W - OFF_W - 2.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
cpu_pc  in  32  fetch address (pcF); bits [1:0] ignored.
cpu_req  in  1  fetch valid this cycle.
flush  in  1  invalidate all lines (fence/self-modifying code).
cpu_instr  out  32  instruction word; valid when cpu_req && !cpu_stall.
cpu_stall  out  1  fetch must hold; combinational.
mem_req  out  1  word read request, registered.
mem_addr  out  32  word-aligned read address, registered.
mem_rdata  in  32  returned word.
mem_rvalid  in  1  one-cycle pulse; mem_rdata valid for the oldest outstanding request.

Behaviour:
- Address split: tag = pc[31:32-TAG_W], index = pc[INDEX_W+OFF_W+1:OFF_W+2], offset = pc[OFF_W+1:2].
- Storage:
  - valid[LINES] and tag[LINES] are flops.
  - Data is LINES*WORDS_PER_LINE x 32 with one synchronous write and an asynchronous read.
- hit = valid[index] && tag[index]==tag(cpu_pc) && state==IDLE.
- cpu_stall = cpu_req && !hit. cpu_instr = hit ? data[index][offset] : 0.
- FSM states: IDLE, REFILL.
  - IDLE, cpu_req && !hit:
    - Latch line base {tag, index}, set word counter cnt=0, set kill=0.
    - Next cycle: state REFILL, mem_req=1, mem_addr = {line base, cnt, 2'b00}.
  - REFILL, mem_req stays high and mem_addr stays stable until mem_rvalid:
    - On mem_rvalid: write mem_rdata to data[index][cnt].
    - If cnt < WORDS_PER_LINE-1: cnt+1, and mem_addr updates the same edge.
    - Otherwise: tag[index] <= latched tag; valid[index] <= !kill; mem_req <= 0; state <= IDLE.
  - Exactly one request is outstanding at a time; gaps of any length between mem_rvalid pulses are legal.
- Miss penalty: stall cycle 0 → mem_req from cycle 1 → N rvalids → IDLE on the edge after the last rvalid → hit, stall low.
  - With back-to-back rvalid: WORDS_PER_LINE+1 stall cycles.
- cpu_pc changing during REFILL:
  - The refill finishes for the latched line.
  - On return to IDLE the current cpu_pc is looked up again; it may miss again.
- flush:
  - Clears all valid bits on the next edge, in any state.
  - In REFILL it also sets kill=1; the line is still written, but its valid bit stays 0.
- mem_rvalid while in IDLE is ignored, with no array writes.
- cpu_req=0: no lookup side effects; cpu_stall=0.
- rst, including mid-refill:
  - Outputs and state: state=IDLE, mem_req=0, mem_addr=0, cnt=0, kill=0, all valid=0.
  - Tag and data arrays are not reset.
  - cpu_stall after reset equals cpu_req, because every lookup misses.
- Simultaneous flush and refill completion: flush wins; the line ends invalid.

Decomposition:
- Shared package icache_pkg:
  - state enum (IDLE, REFILL);
  - localparams INDEX_W, OFF_W, TAG_W, derived from LINES and WORDS_PER_LINE;
  - field-extract functions get_tag, get_index and get_offset.
- One sub-module, icache_data_ram: LINES*WORDS_PER_LINE x 32 storage, synchronous write (we, waddr, wdata), asynchronous read (raddr → rdata).
- Tag/valid arrays and the FSM stay in inst_cache.

Test Plan:
1. Cold miss: after rst, cpu_req=1, cpu_pc=0xBFC00000, memory returns rvalid every cycle with data = address → cpu_stall=1 for 5 cycles; mem_addr sequence 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; then cpu_stall=0 and cpu_instr=0xBFC00000.
2. Line hits: following scenario 1, cpu_pc=0xBFC00004, then 0x08, then 0x0C → cpu_stall=0 each cycle, mem_req never asserted, cpu_instr equals the address.
3. Conflict eviction: cpu_pc=0xBFC00400 (same index 0, different tag) → miss and refill; a subsequent 0xBFC00000 misses again and refetches 4 words.
4. Irregular memory: rvalid after 3, 0, 7 and 1 idle cycles → mem_addr stays stable while waiting, exactly 4 words are written, stall drops on the cycle after the 4th rvalid.
5. Flush during refill: flush=1 pulsed after the 2nd rvalid for pc 0x00400000 → refill completes; the next lookup of 0x00400000 misses; a line cached earlier also misses.
6. Reset mid-refill: rst=1 after 2 rvalids → mem_req=0 next cycle; a late rvalid is ignored; the next fetch of the same pc performs a full 4-word refill.
